demux_1x4_registered: RTL and testbench

Registered 1:4 demultiplexer with valid/ready handshakes: the steering counterpart of the 4:1 mux tree. It takes a single input stream where each word carries a 2-bit destination select, and delivers each word to one of four output channels. Each channel has its own one-entry holding register and a delivered-word counter. It sits where one shared producer fans out to four independent consumers.

---
 rtl/demux_1x4_registered_pkg.sv | 10 +
 rtl/demux_1x4_registered_if.sv | 24 ++
 rtl/demux_1x4_registered_slot.sv | 62 ++++++
 rtl/demux_1x4_registered.sv | 53 +++++
 tb/tb_demux_1x4_registered.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_1x4_registered_pkg.sv
// Shared constants and the channel state type for the registered 1:4 demultiplexer.
package demux_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/demux_1x4_registered_if.sv
// Input stream plus four output channels with delivered-word counters.
interface demux_1x4_registered_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in;
  logic [1:0]           sel;
  logic [4*WIDTH-1:0]   out;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [4*CNT_W-1:0]   count;

  modport master (
    output in_valid, in, sel, out_ready,
    input  in_ready, out, out_valid, count
  );

  modport slave (
    input  in_valid, in, sel, out_ready,
    output in_ready, out, out_valid, count
  );
endinterface

// File: rtl/demux_1x4_registered_slot.sv
// One output channel: single-entry holding register, occupancy FSM and pop counter.
//   state | meaning
//   EMPTY | no word held, o_valid = 0
//   FULL  | word held in r_q, o_valid = 1
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);
  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = (r_state == FULL) & i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A load while popping keeps the slot FULL, so the stream has no bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (i_load) w_state_nxt = FULL;
      FULL: begin
        if (i_load)           w_state_nxt = FULL;
        else if (i_out_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      r_count <= '0;
    end else begin
      if (i_load) r_q <= i_d;
      if (w_pop)  r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_q     = r_q;
  assign o_valid = (r_state == FULL);
  assign o_count = r_count;
endmodule

// File: rtl/demux_1x4_registered.sv
// Registered 1:4 demultiplexer: steers each input word to the channel named by sel.
module demux_1x4_registered
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_1x4_registered_if.slave  bus
);
  logic [NCH-1:0]       w_load;
  logic [NCH-1:0]       w_valid;
  logic [NCH-1:0]       w_slot_rdy;
  logic [NCH*WIDTH-1:0] w_out;
  logic [NCH*CNT_W-1:0] w_count;
  logic                 w_in_ready;
  logic                 w_acc;

  // Only the addressed channel can stall the input; in_valid never feeds in_ready.
  assign w_in_ready = w_slot_rdy[bus.sel];
  assign w_acc      = bus.in_valid & w_in_ready;

  always_comb begin
    w_load = '0;
    for (int k = 0; k < NCH; k++) begin
      w_load[k] = w_acc & (bus.sel == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    assign w_slot_rdy[g] = ~w_valid[g] | bus.out_ready[g];

    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load[g]),
      .i_d         (bus.in),
      .i_out_ready (bus.out_ready[g]),
      .o_q         (w_out[g*WIDTH +: WIDTH]),
      .o_valid     (w_valid[g]),
      .o_count     (w_count[g*CNT_W +: CNT_W])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out       = w_out;
  assign bus.out_valid = w_valid;
  assign bus.count     = w_count;
endmodule

// File: tb/tb_demux_1x4_registered.sv
// Randomized and directed bench for demux_1x4_registered against an array-based channel model.
module tb_demux_1x4_registered;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic       m_valid [4];
  logic [7:0] m_data  [4];
  logic [7:0] m_count [4];
  logic [7:0] delivered [$];

  demux_1x4_registered_if #(.WIDTH(8), .CNT_W(8)) bus ();

  demux_1x4_registered #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 8'h00;
      m_count[k] = 8'h00;
    end
  endtask

  // One clock: drive at negedge, check in_ready, update model at posedge, check state at next negedge.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic [1:0] s, input logic [3:0] r);
    logic        exp_rdy;
    logic        acc;
    logic [3:0]  exp_v;
    logic [31:0] exp_o;
    logic [31:0] exp_c;
    bus.in_valid  = v;
    bus.in        = d;
    bus.sel       = s;
    bus.out_ready = r;
    #1;
    exp_rdy = !m_valid[s] || r[s];
    tests++;
    if (bus.in_ready !== exp_rdy) begin
      fails++;
      $display("FAIL in_ready sel=%0d got=%b exp=%b", s, bus.in_ready, exp_rdy);
    end
    if (bus.out_valid[2] && r[2]) delivered.push_back(bus.out[23:16]);
    @(posedge clk);
    acc = v && exp_rdy;
    for (int k = 0; k < 4; k++) begin
      if (m_valid[k] && r[k]) begin
        m_count[k] = m_count[k] + 8'd1;
        m_valid[k] = 1'b0;
      end
      if (acc && (int'(s) == k)) begin
        m_valid[k] = 1'b1;
        m_data[k]  = d;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v[k]          = m_valid[k];
      exp_o[k*8 +: 8]   = m_data[k];
      exp_c[k*8 +: 8]   = m_count[k];
    end
    tests++;
    if (bus.out_valid !== exp_v) begin
      fails++;
      $display("FAIL out_valid got=%b exp=%b", bus.out_valid, exp_v);
    end
    tests++;
    if (bus.out !== exp_o) begin
      fails++;
      $display("FAIL out got=%h exp=%h", bus.out, exp_o);
    end
    tests++;
    if (bus.count !== exp_c) begin
      fails++;
      $display("FAIL count got=%h exp=%h", bus.count, exp_c);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in        = 8'h00;
    bus.sel       = 2'd0;
    bus.out_ready = 4'b0000;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
    tests++;
    if (bus.count !== 32'h0) begin fails++; $display("FAIL reset_count got=%h exp=0", bus.count); end
    tests++;
    if (bus.out !== 32'h0) begin fails++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive_cycle(1'b1, 8'hC2, 2'd2, 4'b0000);
    drive_cycle(1'b0, 8'h00, 2'd0, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL async_reset_valid got=%b exp=0000", bus.out_valid); end
    tests++;
    if (bus.count !== 32'h0) begin fails++; $display("FAIL async_reset_count got=%h exp=0", bus.count); end
    model_clear();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_steering();
    apply_reset();
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 8'hA0 + 8'(k), 2'(k), 4'b0000);
    tests++;
    if (bus.out_valid !== 4'b1111) begin fails++; $display("FAIL steer_valid got=%b exp=1111", bus.out_valid); end
    tests++;
    if (bus.out !== 32'hA3A2A1A0) begin fails++; $display("FAIL steer_data got=%h exp=a3a2a1a0", bus.out); end
    bus.in_valid = 1'b1; bus.in = 8'hA4; bus.sel = 2'd1; bus.out_ready = 4'b0000;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL steer_stall got=%b exp=0", bus.in_ready); end
    drive_cycle(1'b1, 8'hA4, 2'd1, 4'b0000);
  endtask

  task automatic test_blocking();
    apply_reset();
    drive_cycle(1'b1, 8'h11, 2'd1, 4'b0000);
    bus.in_valid = 1'b1; bus.in = 8'h33; bus.sel = 2'd1; bus.out_ready = 4'b0000;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL block_sel1 got=%b exp=0", bus.in_ready); end
    drive_cycle(1'b1, 8'h33, 2'd1, 4'b0000);
    bus.sel = 2'd3;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL block_sel3 got=%b exp=1", bus.in_ready); end
    drive_cycle(1'b1, 8'h33, 2'd3, 4'b0000);
    tests++;
    if (bus.out_valid !== 4'b1010) begin fails++; $display("FAIL block_valid got=%b exp=1010", bus.out_valid); end
    tests++;
    if (bus.out[31:24] !== 8'h33 || bus.out[15:8] !== 8'h11) begin
      fails++; $display("FAIL block_data got=%h exp=33xx11xx", bus.out);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    delivered.delete();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 8'h10 + 8'(i), 2'd2, 4'b0100);
      tests++;
      if (bus.out_valid[2] !== 1'b1) begin fails++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, bus.out_valid[2]); end
    end
    drive_cycle(1'b0, 8'h00, 2'd2, 4'b0100);
    tests++;
    if (delivered.size() != 10) begin
      fails++; $display("FAIL b2b_ndeliv got=%0d exp=10", delivered.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (delivered[i] !== 8'h10 + 8'(i)) begin
          fails++; $display("FAIL b2b_order i=%0d got=%h exp=%h", i, delivered[i], 8'h10 + 8'(i));
        end
      end
    end
    tests++;
    if (bus.count[23:16] !== 8'd10) begin fails++; $display("FAIL b2b_count got=%0d exp=10", bus.count[23:16]); end
    tests++;
    if (bus.out_valid[2] !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid[2]); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    drive_cycle(1'b1, 8'h0A, 2'd0, 4'b0000);
    drive_cycle(1'b1, 8'h3A, 2'd3, 4'b0000);
    drive_cycle(1'b1, 8'h5A, 2'd1, 4'b1001);
    tests++;
    if (bus.out_valid !== 4'b0010) begin fails++; $display("FAIL simul_valid got=%b exp=0010", bus.out_valid); end
    tests++;
    if (bus.count !== 32'h01000001) begin fails++; $display("FAIL simul_count got=%h exp=01000001", bus.count); end
    tests++;
    if (bus.out[15:8] !== 8'h5A) begin fails++; $display("FAIL simul_data got=%h exp=5a", bus.out[15:8]); end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive_cycle(1'b1, 8'h77, 2'd1, 4'b0000);
    drive_cycle(1'b0, 8'h00, 2'd1, 4'b0010);
    for (int i = 0; i < 256; i++) drive_cycle(1'b1, 8'(i), 2'd0, 4'b0001);
    drive_cycle(1'b0, 8'h00, 2'd0, 4'b0001);
    tests++;
    if (bus.count[7:0] !== 8'd0) begin fails++; $display("FAIL wrap_count0 got=%0d exp=0", bus.count[7:0]); end
    tests++;
    if (bus.count[31:8] !== 24'h000001) begin fails++; $display("FAIL wrap_others got=%h exp=000001", bus.count[31:8]); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)), 4'($urandom));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_async_reset();
    test_steering();
    test_blocking();
    test_back_to_back();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
